thread_fetch_scheduler: RTL
===========================

# thread_fetch_scheduler

Round-robin fetch scheduler for the quad hardware-threaded ARM-compatible core. It holds one program counter per thread, picks one eligible thread per cycle, and presents that thread's ID and PC to instruction fetch. Branch redirects and halts come back from later stages, and a configuration port loads start PCs. It sits ahead of the instruction memory and feeds the thread ID down the pipeline, so the decoded control signals and register-file bank stay bound to the issuing thread.

## Interface
- PC_WIDTH, 9, instruction-memory word-address width; all PCs wrap modulo 2^PC_WIDTH
- START_STRIDE, 64, thread t resets to PC = t*START_STRIDE (truncated to PC_WIDTH)
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- thread_en  in  4  per-thread run enable; bit t=0 makes thread t ineligible without changing its state
- stall  in  1  global pipeline stall
- br_valid  in  1  branch resolved, redirect request
- br_tid  in  2  thread being redirected
- br_target  in  PC_WIDTH  new PC for br_tid
- halt_valid  in  1  thread executed halt
- halt_tid  in  2  halting thread
- cfg_we  in  1  load a thread PC and mark the thread active
- cfg_tid  in  2  thread to configure
- cfg_pc  in  PC_WIDTH  PC value to load
- fetch_valid  out  1  fetch_tid/fetch_pc form a valid issue
- fetch_tid  out  2  issued thread
- fetch_pc  out  PC_WIDTH  issued PC
- thread_active  out  4  per-thread active flags

## Operation
- State: pc[0..3], active[3:0], rr_last (2 bits, last granted thread), plus registered fetch outputs.
- Eligibility: thread t is eligible when active[t] & thread_en[t] and not (halt_valid & halt_tid==t).
- Selection, when stall=0: search from rr_last+1 upward, modulo 4. The first eligible thread g is granted.
  - fetch_valid<=1 and fetch_tid<=g.
  - fetch_pc<=P, where P=br_target if br_valid & br_tid==g, else pc[g].
  - pc[g]<=P+1, wrapping to 0 after 2^PC_WIDTH-1.
  - rr_last<=g.
- No eligible thread, stall=0: fetch_valid<=0; fetch_tid, fetch_pc and rr_last hold.
- stall=1: no grant is made. fetch_valid, fetch_tid, fetch_pc and rr_last hold, and no PC increments. Branch, halt and cfg still apply.
- Branch on a thread that is not granted this cycle: pc[br_tid]<=br_target. This applies regardless of active or thread_en.
- Halt: active[halt_tid]<=0. The thread's pc is untouched.
- Cfg: pc[cfg_tid]<=cfg_pc and active[cfg_tid]<=1. The newly loaded thread is not eligible until the next cycle.
- Per-thread priority, highest first: cfg, then branch, then increment. cfg beats halt on the same thread, so active stays 1. The cfg/branch/halt paths can each hit different threads in the same cycle, and all of them apply.
- thread_active is driven directly from active.

## Timing
- Reset (asynchronous, immediate on rst_n=0):
  - fetch_valid=0, fetch_tid=0, fetch_pc=0.
  - active=4'b1111 and rr_last=3, so the first grant goes to thread 0.
  - pc[t]=t*START_STRIDE.
- Latency: the grant decision in cycle N appears on fetch_* after the edge ending cycle N (one registered stage). The first valid issue appears on the first edge after rst_n deasserts, provided stall=0.
- Branch, halt and cfg take effect at the edge of the cycle they are sampled in. A grant in that same cycle already sees the same-cycle branch (bypass) and the same-cycle halt.
- Fairness: with k eligible threads and no stall, each thread is granted exactly once every k cycles.
- Reset asserted mid-operation aborts everything immediately. There is no partial update of any thread state.

## Test plan
- Reset, thread_en=4'hF, stall=0: fetch sequence (tid,pc) = (0,0x000), (1,0x040), (2,0x080), (3,0x0C0), (0,0x001), (1,0x041).
- thread_en=4'b0101 from reset: sequence (0,0x000), (2,0x080), (0,0x001), (2,0x081); threads 1 and 3 never issue and their PCs stay at 0x040 and 0x0C0.
- Redirect-bypass case, with the cycle chosen so thread 1 is the grant:
  - Drive br_valid=1, br_tid=1, br_target=0x1F0 in that cycle -> fetch=(1,0x1F0).
  - Thread 1's next grant -> (1,0x1F1).
  - A branch to thread 3 in a non-grant cycle -> thread 3's next issue uses the target exactly.
- Wrap case:
  - cfg_we, cfg_tid=3, cfg_pc=0x1FF -> thread 3's next two issues are 0x1FF, then 0x000.
- Halt and reactivate thread 2:
  - halt_valid, halt_tid=2 in the cycle thread 2 would be granted -> thread 3 is granted instead; thread_active=4'b1011; thread 2 stays skipped.
  - Then cfg_we, cfg_tid=2, cfg_pc=0x080 -> thread_active=4'hF; thread 2 issues 0x080 on its next turn.
- Stall and mid-operation reset:
  - Hold stall=1 for 3 cycles -> fetch_* is frozen and PCs do not advance.
  - br_valid for thread 0 during the stall -> thread 0 resumes at the branch target.
  - Pull rst_n low mid-run -> fetch_valid=0 immediately; after release, the sequence restarts at (0,0x000).

Source files
------------

// File: rtl/thread_fetch_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | thread_fetch_scheduler: round-robin fetch scheduler for four HW threads.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module thread_fetch_scheduler #(
  parameter int PC_WIDTH     = 9,
  parameter int START_STRIDE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          thread_en,
  input  logic                stall,
  input  logic                br_valid,
  input  logic [1:0]          br_tid,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                halt_valid,
  input  logic [1:0]          halt_tid,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_tid,
  input  logic [PC_WIDTH-1:0] cfg_pc,
  output logic                fetch_valid,
  output logic [1:0]          fetch_tid,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic [3:0]          thread_active
);

  logic [PC_WIDTH-1:0] pc_q [4];
  logic [PC_WIDTH-1:0] pc_d [4];
  logic [3:0]          active_q, active_d;
  logic [1:0]          rr_last_q, rr_last_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [1:0]          fetch_tid_q, fetch_tid_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  logic [3:0]          w_eligible;
  logic                w_found;
  logic [1:0]          w_grant_tid;
  logic                w_issue;
  logic [PC_WIDTH-1:0] w_issue_pc;

  // A same-cycle halt already removes the thread from this cycle's search.
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      w_eligible[t] = active_q[t] & thread_en[t] & ~(halt_valid && (halt_tid == 2'(t)));
    end
  end

  always_comb begin
    logic [1:0] cand;
    cand        = rr_last_q;
    w_found     = 1'b0;
    w_grant_tid = rr_last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = rr_last_q + 2'(i);
      if (!w_found && w_eligible[cand]) begin
        w_found     = 1'b1;
        w_grant_tid = cand;
      end
    end
  end

  assign w_issue    = w_found & ~stall;
  assign w_issue_pc = (br_valid && (br_tid == w_grant_tid)) ? br_target : pc_q[w_grant_tid];

  // Priority per thread: cfg over branch over increment; later writes win.
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      pc_d[t] = pc_q[t];
    end
    active_d      = active_q;
    rr_last_d     = rr_last_q;
    fetch_valid_d = fetch_valid_q;
    fetch_tid_d   = fetch_tid_q;
    fetch_pc_d    = fetch_pc_q;

    if (w_issue) begin
      pc_d[w_grant_tid] = w_issue_pc + PC_WIDTH'(1);
      rr_last_d         = w_grant_tid;
      fetch_valid_d     = 1'b1;
      fetch_tid_d       = w_grant_tid;
      fetch_pc_d        = w_issue_pc;
    end else if (!stall) begin
      fetch_valid_d = 1'b0;
    end

    if (br_valid && !(w_issue && (br_tid == w_grant_tid))) begin
      pc_d[br_tid] = br_target;
    end
    if (halt_valid) begin
      active_d[halt_tid] = 1'b0;
    end
    if (cfg_we) begin
      pc_d[cfg_tid]     = cfg_pc;
      active_d[cfg_tid] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 4; t++) begin
        pc_q[t] <= PC_WIDTH'(t * START_STRIDE);
      end
      active_q      <= 4'b1111;
      rr_last_q     <= 2'd3;
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= 2'd0;
      fetch_pc_q    <= '0;
    end else begin
      for (int t = 0; t < 4; t++) begin
        pc_q[t] <= pc_d[t];
      end
      active_q      <= active_d;
      rr_last_q     <= rr_last_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_tid_q   <= fetch_tid_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign fetch_valid   = fetch_valid_q;
  assign fetch_tid     = fetch_tid_q;
  assign fetch_pc      = fetch_pc_q;
  assign thread_active = active_q;

endmodule
`default_nettype wire
